hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, datapath and forwarded-result width.
REQ-002 Parameter FWD_DEPTH, default 2, range 1..4, number of downstream stages tracked for forwarding.
REQ-003 Parameter LOAD_LAT, default 1, range 0..FWD_DEPTH, first tracker index at which load data is valid.
REQ-004 Port clk, input, 1, clock; the block is clocked on clk.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port id_valid, input, 1, the ID-stage instruction is valid.
REQ-007 Port id_instr, input, 16, the ID-stage instruction: opcode [15:12], rs [11:9], rt [8:6], rd [5:3].
REQ-008 Port flush, input, 1, branch taken; kills the ID-stage instruction.
REQ-009 Port stage_data, input, FWD_DEPTH*DATA_W, result of tracker entry i, located at slice [i*DATA_W +: DATA_W].
REQ-010 Port fwd_op1_sel / fwd_op2_sel, output, SEL_W = clog2(FWD_DEPTH+1) each, operand source select.
REQ-011 Port fwd_op1 / fwd_op2, output, DATA_W each, forwarded operand value.
REQ-012 Port stall, output, 1, hold IF/ID and insert a bubble.
REQ-013 Port stall_cycles, output, 16, count of stall cycles since reset.

Function
REQ-014 Decode SHALL be as follows:
- opcode 0: reads rs and rt; writes rd.
- opcodes 1 and 3: read rs; write rt.
- opcode 4 (lw): reads rs; writes rt; is a load.
- opcodes 5 and 6: read rs and rt; write nothing.
- All other opcodes: read and write nothing.
REQ-015 The tracker SHALL hold FWD_DEPTH entries of {valid, dst, is_load}; entry 0 is the instruction in EX.
REQ-016 The tracker SHALL shift every cycle; entry FWD_DEPTH-1 is discarded.
REQ-017 The new entry 0 SHALL come from the ID instruction, and SHALL be invalid when any of the following holds: id_valid=0, stall=1, flush=1, or the instruction writes nothing.
REQ-018 A tracker entry match SHALL require all of: valid=1, dst equal to the used source, and source not equal to r0.
REQ-019 Selects, data and stall SHALL be combinational from tracker state and ID inputs (zero latency).
REQ-020 Select encoding SHALL be: 0 = register file; k = stage_data entry k-1.
REQ-021 The select SHALL point to the youngest (lowest-index) match.
REQ-022 fwd_opN SHALL equal the selected stage_data slice, or 0 when the select is 0.
REQ-023 stall SHALL be 1 when a used source matches a load entry at index below LOAD_LAT.
REQ-024 While stall=1, both selects SHALL be 0; the upstream stage re-presents the same instruction.
REQ-025 flush=1 SHALL force stall=0 and both selects to 0; flush has priority over stall.
REQ-026 id_valid=0 SHALL force stall=0 and both selects to 0.
REQ-027 stall_cycles SHALL increment on each cycle with stall=1 and saturate at 0xFFFF.

Reset
REQ-028 When rst=1 at a clk edge, all tracker entries SHALL be set invalid and stall_cycles SHALL be cleared to 0.
REQ-029 As a result of reset, in the cycle after reset with stall_cycles=0: stall=0, selects=0, and fwd_op1/fwd_op2=0.
REQ-030 Reset asserted during a stall SHALL drop stall in the next cycle unless a new load-use hazard is presented.

Structure
REQ-031 A shared package hazard_pkg SHALL hold the opcode constants, the tracker entry struct, and the source/destination decode function.
REQ-032 A single sub-module hazard_fwd_match SHALL perform per-operand youngest-match selection and SHALL be instantiated twice.

Verification (DATA_W=16, FWD_DEPTH=2, LOAD_LAT=1)
REQ-033 Scenario: 0x0258 (add r3) then 0x06E0 (add r4,r3,r3), with stage_data[0]=0x1234 -> both selects=1, fwd_op1=fwd_op2=0x1234, stall=0.
REQ-034 Scenario: 0x0258, then an id_valid=0 cycle, then 0x06E0, with stage_data[1]=0xBEEF -> both selects=2, fwd_op1=0xBEEF.
REQ-035 Scenario: 0x4280 (lw r2) then 0x04A8 held -> stall=1 for exactly one cycle, then selects=2, stall_cycles=1.
REQ-036 Scenario: an instruction writing r0, followed by an instruction reading r0 -> both selects=0, no stall.
REQ-037 Scenario: 0x4280 then 0x04A8 with flush=1 on the same cycle -> stall=0, and next-cycle entry 0 is invalid.
REQ-038 Scenario: rst=1 during a stall -> next cycle stall=0, stall_cycles=0, tracker empty.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared decode constants, tracker entry layout and instruction decode for the hazard unit.
package hazard_pkg;

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;

  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       is_load;
  } track_entry_t;

  typedef struct packed {
    logic       rd_rs;
    logic       rd_rt;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       wr;
    logic [2:0] dst;
    logic       is_load;
  } decode_t;

  function automatic decode_t decode_instr(input logic [15:0] instr);
    decode_t d;
    d         = '0;
    d.rs      = instr[11:9];
    d.rt      = instr[8:6];
    case (instr[15:12])
      OP_ALU: begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
        d.wr    = 1'b1;
        d.dst   = instr[5:3];
      end
      OP_ADDI, OP_ORI: begin
        d.rd_rs = 1'b1;
        d.wr    = 1'b1;
        d.dst   = instr[8:6];
      end
      OP_LW: begin
        d.rd_rs   = 1'b1;
        d.wr      = 1'b1;
        d.dst     = instr[8:6];
        d.is_load = 1'b1;
      end
      OP_BEQ, OP_SW: begin
        d.rd_rs = 1'b1;
        d.rd_rt = 1'b1;
      end
      default: d = d;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Youngest-match forwarding select and load-use detection for one source operand.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = 2
) (
  input  logic                          used,
  input  logic [2:0]                    src,
  input  track_entry_t [FWD_DEPTH-1:0]  tracker,
  output logic [SEL_W-1:0]              sel,
  output logic                          load_hit
);

  logic hit;

  // Walk oldest to youngest so the lowest-index match ends up selected.
  always_comb begin
    sel      = '0;
    load_hit = 1'b0;
    hit      = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      hit      = used & (src != 3'd0) & tracker[i].valid & (tracker[i].dst == src);
      sel      = hit ? SEL_W'(i + 1) : sel;
      load_hit = load_hit | (hit & tracker[i].is_load & (i < LOAD_LAT));
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight writers, forwards results, stalls on load-use.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [15:0]                 id_instr,
  input  logic                        flush,
  input  logic [FWD_DEPTH*DATA_W-1:0] stage_data,
  output logic [SEL_W-1:0]            fwd_op1_sel,
  output logic [SEL_W-1:0]            fwd_op2_sel,
  output logic [DATA_W-1:0]           fwd_op1,
  output logic [DATA_W-1:0]           fwd_op2,
  output logic                        stall,
  output logic [15:0]                 stall_cycles
);

  track_entry_t [FWD_DEPTH-1:0] tracker_q, tracker_d;
  logic [15:0]                  stall_cycles_q, stall_cycles_d;
  decode_t                      dec;
  logic [SEL_W-1:0]             raw_sel1, raw_sel2;
  logic                         hit1, hit2;
  logic                         live;

  assign dec = decode_instr(id_instr);

  hazard_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_op1 (
    .used     (dec.rd_rs),
    .src      (dec.rs),
    .tracker  (tracker_q),
    .sel      (raw_sel1),
    .load_hit (hit1)
  );

  hazard_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_op2 (
    .used     (dec.rd_rt),
    .src      (dec.rt),
    .tracker  (tracker_q),
    .sel      (raw_sel2),
    .load_hit (hit2)
  );

  // Stall/select gating, operand muxing and next tracker/counter state.
  always_comb begin
    live        = id_valid & ~flush;
    stall       = live & (hit1 | hit2);
    fwd_op1_sel = (live & ~stall) ? raw_sel1 : '0;
    fwd_op2_sel = (live & ~stall) ? raw_sel2 : '0;
    fwd_op1     = '0;
    fwd_op2     = '0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      fwd_op1 = (fwd_op1_sel == SEL_W'(i + 1)) ? stage_data[i*DATA_W +: DATA_W] : fwd_op1;
      fwd_op2 = (fwd_op2_sel == SEL_W'(i + 1)) ? stage_data[i*DATA_W +: DATA_W] : fwd_op2;
    end
    tracker_d            = tracker_q;
    tracker_d[0].valid   = live & ~stall & dec.wr;
    tracker_d[0].dst     = dec.dst;
    tracker_d[0].is_load = dec.is_load;
    for (int i = 1; i < FWD_DEPTH; i++) begin
      tracker_d[i] = tracker_q[i-1];
    end
    stall_cycles_d = (stall && (stall_cycles_q != 16'hFFFF)) ? stall_cycles_q + 16'd1
                                                            : stall_cycles_q;
  end

  // Tracker shift register and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tracker_q      <= '0;
      stall_cycles_q <= 16'd0;
    end else begin
      tracker_q      <= tracker_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
